// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone arbiter for the PSRAM burst controller: round-robin grant held
// for a whole cycle, one forced idle gap between owners, per-grant ack watchdog.
module psram_wb_arbiter #(
    parameter int address_width  = 16,
    parameter int data_width     = 16,
    parameter int timeout_cycles = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [address_width-1:0] m0_adr_i,
    input  logic [data_width-1:0]    m0_dat_i,
    output logic [data_width-1:0]    m0_dat_o,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,

    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [address_width-1:0] m1_adr_i,
    input  logic [data_width-1:0]    m1_dat_i,
    output logic [data_width-1:0]    m1_dat_o,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,

    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [address_width-1:0] s_adr_o,
    output logic [data_width-1:0]    s_dat_o,
    input  logic [data_width-1:0]    s_dat_i,
    input  logic                     s_ack_i,

    output logic [1:0]               grant_o
);

    // state | meaning
    // idle  | no owner, arbitrate between requests
    // own0  | master 0 owns the controller port
    // own1  | master 1 owns the controller port
    // gap   | one cycle with cyc low before the next arbitration
    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_own0 = 2'd1;
    localparam logic [1:0] st_own1 = 2'd2;
    localparam logic [1:0] st_gap  = 2'd3;

    // The watchdog holds the ack-less cycles already spent, so the limit is one less
    // than the timeout: the error lands on the timeout_cycles-th ack-less cycle.
    localparam logic [7:0] wd_limit = 8'(timeout_cycles - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_owner;
    logic [7:0] watchdog;
    logic       req0;
    logic       req1;
    logic       own0;
    logic       own1;
    logic       own_cyc;
    logic       timeout;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign own0    = (state == st_own0);
    assign own1    = (state == st_own1);
    assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    // A late ack on the limit cycle wins over the timeout.
    assign timeout = own_cyc & ~s_ack_i & (watchdog == wd_limit);
    assign grant_o = {own1, own0};

    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: begin
                if (req0 & (~req1 | last_owner)) begin
                    state_nxt = st_own0;
                end else if (req1) begin
                    state_nxt = st_own1;
                end
            end
            st_own0, st_own1: begin
                if (~own_cyc | timeout) begin
                    state_nxt = st_gap;
                end
            end
            st_gap:  state_nxt = st_idle;
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= st_idle;
            last_owner <= 1'b1;
            watchdog   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == st_idle && state_nxt == st_own0) begin
                last_owner <= 1'b0;
            end else if (state == st_idle && state_nxt == st_own1) begin
                last_owner <= 1'b1;
            end
            if (~(own0 | own1) | s_ack_i) begin
                watchdog <= 8'd0;
            end else begin
                watchdog <= watchdog + 8'd1;
            end
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i & ~timeout;
            s_stb_o  = m0_stb_i & ~timeout;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i & m0_cyc_i;
            m0_err_o = timeout;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i & ~timeout;
            s_stb_o  = m1_stb_i & ~timeout;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i & m1_cyc_i;
            m1_err_o = timeout;
        end
    end

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Bench for psram_wb_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_psram_wb_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wdat, m0_rdat;
    logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wdat, m1_rdat;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat, s_rdat;
    logic [1:0]    grant;

    psram_wb_arbiter #(
        .address_width (AW),
        .data_width    (DW),
        .timeout_cycles(TO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o (s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o (s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .grant_o (grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether a gap cycle is pending,
    // who was granted last, and how many ack-less owned cycles have elapsed.
    int owner, cooldown, last_own, quiet;

    task automatic model_reset();
        owner = -1; cooldown = 0; last_own = 1; quiet = 0;
    endtask

    logic          o_scyc, o_ack0, o_err0, o_ack1, o_err1;
    logic [1:0]    o_grant;
    logic [DW-1:0] o_rdat0;

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0;
        s_ack = 0; s_rdat = '0;
    endtask

    // Called at posedge+1 with inputs already applied; checks and returns at next posedge+1.
    task automatic cycle();
        logic ec, es, ew, ea0, ee0, ea1, ee1, c, hit, r0, r1;
        logic [1:0]    eg;
        logic [AW-1:0] eadr;
        logic [DW-1:0] ewd, ed0, ed1;
        #3;
        ec = 0; es = 0; ew = 0; ea0 = 0; ee0 = 0; ea1 = 0; ee1 = 0; c = 0; hit = 0;
        eg = 2'b00; eadr = '0; ewd = '0; ed0 = '0; ed1 = '0;
        if (owner >= 0) begin
            c    = (owner == 0) ? m0_cyc : m1_cyc;
            hit  = c && !s_ack && (quiet + 1 == TO);
            ec   = c && !hit;
            es   = ((owner == 0) ? m0_stb : m1_stb) && !hit;
            ew   = (owner == 0) ? m0_we : m1_we;
            eadr = (owner == 0) ? m0_adr : m1_adr;
            ewd  = (owner == 0) ? m0_wdat : m1_wdat;
            if (owner == 0) begin
                ed0 = s_rdat; ea0 = s_ack && c; ee0 = hit; eg = 2'b01;
            end else begin
                ed1 = s_rdat; ea1 = s_ack && c; ee1 = hit; eg = 2'b10;
            end
        end
        check("ctl", 64'({s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err, grant}),
                     64'({ec, es, ew, ea0, ee0, ea1, ee1, eg}));
        check("bus", {s_adr, s_wdat, m0_rdat, m1_rdat}, {eadr, ewd, ed0, ed1});
        o_scyc = s_cyc; o_ack0 = m0_ack; o_err0 = m0_err; o_ack1 = m1_ack; o_err1 = m1_err;
        o_grant = grant; o_rdat0 = m0_rdat;
        if (owner >= 0) begin
            if (!c || hit) begin
                owner = -1; cooldown = 1;
            end else if (s_ack) begin
                quiet = 0;
            end else begin
                quiet++;
            end
        end else if (cooldown != 0) begin
            cooldown = 0;
        end else begin
            r0 = m0_cyc && m0_stb;
            r1 = m1_cyc && m1_stb;
            if (r0 && r1)  owner = 1 - last_own;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            if (owner >= 0) begin
                last_own = owner; quiet = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int gap, got, ngr, acks1, badg, errs, errat;
        logic prev_any, drop0, drop1, ack0seen, scyc_at, ackany;

        // Reset with live inputs: everything must stay quiet.
        idle_inputs();
        rst = 1;
        model_reset();
        m0_cyc = 1; m0_stb = 1; s_ack = 1; s_rdat = 16'h1234;
        #12;
        check("rst_ctl", 64'({s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err, grant}), 64'd0);
        check("rst_bus", {s_adr, s_wdat, m0_rdat, m1_rdat}, 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 0;

        // Single master read at 0x0010, ack on the 4th owned cycle.
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 16'h0010;
        cycle();
        check("sr_idle_cyc", 64'(o_scyc), 64'd0);
        cycle();
        check("sr_cyc_rise", 64'(o_scyc), 64'd1);
        check("sr_grant", 64'(o_grant), 64'(2'b01));
        cycle();
        cycle();
        s_ack = 1; s_rdat = 16'hBEEF;
        cycle();
        check("sr_ack", 64'(o_ack0), 64'd1);
        check("sr_dat", 64'(o_rdat0), 64'hBEEF);
        s_ack = 0; s_rdat = '0; m0_cyc = 0; m0_stb = 0;
        cycle();
        cycle();
        check("sr_gap_grant", 64'(o_grant), 64'd0);
        cycle();
        check("sr_idle_grant", 64'(o_grant), 64'd0);

        // Simultaneous request right after reset: m0 first, m1 after two idle cycles.
        rst = 1;
        model_reset();
        cycle();
        rst = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        cycle();
        cycle();
        check("sim_first", 64'(o_grant), 64'(2'b01));
        s_ack = 1;
        cycle();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        cycle();
        gap = 0; got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            cycle();
            if (o_grant == 2'b00) gap++;
            else got = int'(o_grant);
        end
        check("sim_gap", 64'(gap), 64'd2);
        check("sim_second", 64'(got), 64'(2'b10));
        m1_cyc = 0; m1_stb = 0;
        for (int k = 0; k < 3; k++) cycle();

        // Fairness: both keep re-requesting; each drops cyc right after its ack.
        s_ack = 1; ngr = 0; prev_any = 0; drop0 = 0; drop1 = 0;
        for (int k = 0; k < 80 && ngr < 6; k++) begin
            m0_cyc = !drop0; m0_stb = !drop0;
            m1_cyc = !drop1; m1_stb = !drop1;
            cycle();
            if (o_grant != 2'b00 && !prev_any) begin
                check($sformatf("fair_%0d", ngr), 64'(o_grant), (ngr % 2 == 1) ? 64'd2 : 64'd1);
                ngr++;
            end
            prev_any = (o_grant != 2'b00);
            drop0 = o_ack0;
            drop1 = o_ack1;
        end
        check("fair_count", 64'(ngr), 64'd6);
        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();

        // Burst lock: m1 holds 32 beats while m0 requests throughout.
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 16'h0200; m1_wdat = 16'h5A5A;
        cycle();
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        acks1 = 0; badg = 0; ack0seen = 0;
        for (int k = 0; k < 100 && acks1 < 32; k++) begin
            cycle();
            if (o_ack1) acks1++;
            if (o_ack0) ack0seen = 1;
            if (o_grant != 2'b10) badg++;
        end
        check("burst_acks", 64'(acks1), 64'd32);
        check("burst_m0_ack", 64'(ack0seen), 64'd0);
        check("burst_grant", 64'(badg), 64'd0);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        cycle();
        gap = 0; got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            cycle();
            if (o_grant == 2'b00) gap++;
            else got = int'(o_grant);
        end
        check("burst_gap", 64'(gap), 64'd2);
        check("burst_next", 64'(got), 64'(2'b01));
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();

        // Timeout: no ack ever, error on the 8th owned cycle.
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0ABC;
        cycle();
        errs = 0; errat = 0; scyc_at = 1; ackany = 0;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            if (o_err0) begin
                errs++; errat = n; scyc_at = o_scyc;
            end
            if (o_ack0) ackany = 1;
        end
        check("to_err_cycle", 64'(errat), 64'd8);
        check("to_scyc_drop", 64'(scyc_at), 64'd0);
        check("to_no_ack", 64'(ackany), 64'd0);
        for (int n = 0; n < 2; n++) begin
            cycle();
            if (o_err0) errs++;
        end
        check("to_pulse", 64'(errs), 64'd1);
        m0_cyc = 0; m0_stb = 0;
        for (int k = 0; k < 3; k++) cycle();

        // Timeout variant: ack on the 8th cycle wins and clears the watchdog.
        m0_cyc = 1; m0_stb = 1;
        cycle();
        errs = 0;
        for (int n = 1; n <= 7; n++) begin
            cycle();
            if (o_err0) errs++;
        end
        s_ack = 1; s_rdat = 16'h00C8;
        cycle();
        check("tov_ack", 64'(o_ack0), 64'd1);
        check("tov_err", 64'(o_err0), 64'd0);
        s_ack = 0;
        for (int n = 1; n <= 7; n++) begin
            cycle();
            if (o_err0) errs++;
        end
        check("tov_cleared", 64'(errs), 64'd0);
        cycle();
        check("tov_err_after", 64'(o_err0), 64'd1);
        m0_cyc = 0; m0_stb = 0;
        for (int k = 0; k < 3; k++) cycle();

        // Async reset while m1 owns mid-burst.
        m1_cyc = 1; m1_stb = 1; s_ack = 1;
        cycle();
        cycle();
        cycle();
        #2;
        rst = 1;
        #1;
        check("ar_scyc", 64'(s_cyc), 64'd0);
        check("ar_grant", 64'(grant), 64'd0);
        check("ar_ack", 64'(m1_ack), 64'd0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        idle_inputs();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        cycle();
        cycle();
        check("ar_first", 64'(o_grant), 64'(2'b01));
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
            m0_stb  = ($urandom_range(0, 3) != 0);
            m1_stb  = ($urandom_range(0, 3) != 0);
            m0_we   = 1'($urandom);
            m1_we   = 1'($urandom);
            m0_adr  = 16'($urandom);
            m1_adr  = 16'($urandom);
            m0_wdat = 16'($urandom);
            m1_wdat = 16'($urandom);
            s_ack   = ($urandom_range(0, 3) == 0);
            s_rdat  = 16'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
